// File: rtl/adder_tree_pkg.sv
// ============================================================================
//  Module      : adder_tree_pkg
//  Description : Shared types and constants for the adder-tree arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_tree_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    localparam int STAT_W = 16;

    // One level per addend pair plus the output register of the tree.
    function automatic int default_tree_lat(input int num_addend);
        return $clog2(num_addend) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot grant; pointer advances only on accept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               grant_vld_o
);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant_o     = '0;
        grant_id_o  = '0;
        grant_vld_o = 1'b0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                grant_id_o = cand;
            end
        end
        grant_vld_o = en_i && found;
        if (grant_vld_o) begin
            grant_o[grant_id_o] = 1'b1;
        end
        last_d = grant_vld_o ? grant_id_o : last_q;
    end

    // Reset to the highest index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_tree_arbiter.sv
// ============================================================================
//  Module      : adder_tree_arbiter
//  Description : Shares one pipelined adder tree between NUM_REQ requesters,
//                tags each issue with its requester ID and supports draining.
//                Optional grant counters: define ADDER_TREE_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_arbiter
    import adder_tree_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADD_LENGTH = 16,
    parameter int SUM_LENGTH = 32,
    parameter int NUM_ADDEND = 15,
    parameter int TREE_LAT   = default_tree_lat(NUM_ADDEND),
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
`ifdef ADDER_TREE_ARB_STATS_EN
    input  logic                                   stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]              stat_grants,
`endif
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUM_ADDEND*ADD_LENGTH-1:0] req_addends,
    output logic [NUM_ADDEND*ADD_LENGTH-1:0]       tree_addends,
    input  logic [SUM_LENGTH-1:0]                  tree_sum,
    output logic                                   res_valid,
    output logic [ID_W-1:0]                        res_id,
    output logic [SUM_LENGTH-1:0]                  res_sum,
    input  logic                                   drain,
    output logic                                   drain_done,
    output logic                                   busy
);

    localparam int VEC_W = NUM_ADDEND * ADD_LENGTH;

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic                 run_en;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      win_id;
    logic                 xfer;
    logic                 in_flight;
    logic [VEC_W-1:0]     vec [NUM_REQ];
    logic [TREE_LAT-1:0]  tag_v_q;
    logic [ID_W-1:0]      tag_id_q [TREE_LAT];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign vec[g] = req_addends[g*VEC_W +: VEC_W];
    end

    // Gating with rst keeps grants and status quiet during the reset cycle.
    assign run_en = rst && (state_q == ST_RUN);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .en_i        (run_en),
        .grant_o     (grant),
        .grant_id_o  (win_id),
        .grant_vld_o (xfer)
    );

    assign req_ready    = grant;
    assign tree_addends = xfer ? vec[win_id] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v_q <= '0;
            for (int i = 0; i < TREE_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_v_q[0]  <= xfer;
            tag_id_q[0] <= win_id;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign in_flight  = |tag_v_q;
    assign res_valid  = rst && tag_v_q[TREE_LAT-1];
    assign res_id     = tag_id_q[TREE_LAT-1];
    assign res_sum    = tree_sum;
    assign busy       = rst && in_flight;
    assign drain_done = rst && (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (drain)      state_d = ST_DRAIN;
            ST_DRAIN: if (!in_flight) state_d = ST_DONE;
            ST_DONE:  if (!drain)     state_d = ST_RUN;
            default:                  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ADDER_TREE_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [STAT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!rst || stat_clr) begin
                cnt_q <= '0;
            end else if (grant[g] && (cnt_q != {STAT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_grants[g*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_arbiter.sv
// ============================================================================
//  Module      : tb_adder_tree_arbiter
//  Description : Table-driven bench with result scoreboard and adder-tree model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_tree_arbiter;

    localparam int NR   = 4;
    localparam int AL   = 16;
    localparam int SL   = 32;
    localparam int NA   = 15;
    localparam int TL   = 5;
    localparam int IDW  = 2;
    localparam int VW   = NA * AL;
    localparam int ROWS = 61;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*VW-1:0]  req_addends;
    logic [VW-1:0]     tree_addends;
    logic [SL-1:0]     tree_sum;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [SL-1:0]     res_sum;
    logic              drain;
    logic              drain_done;
    logic              busy;
`ifdef ADDER_TREE_ARB_STATS_EN
    logic              stat_clr;
    logic [NR*16-1:0]  stat_grants;
`endif

    adder_tree_arbiter dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ADDER_TREE_ARB_STATS_EN
        .stat_clr     (stat_clr),
        .stat_grants  (stat_grants),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addends  (req_addends),
        .tree_addends (tree_addends),
        .tree_sum     (tree_sum),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_sum      (res_sum),
        .drain        (drain),
        .drain_done   (drain_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [SL-1:0] vsum(input logic [VW-1:0] v);
        logic [SL-1:0] s;
        s = '0;
        for (int k = 0; k < NA; k++) s = s + {16'b0, v[k*AL +: AL]};
        return s;
    endfunction

    // Adder-tree model: sum sampled at each edge, visible TL cycles later.
    logic [SL-1:0] tpipe [TL];
    always @(posedge clk) begin
        tpipe[0] <= vsum(tree_addends);
        for (int i = 1; i < TL; i++) tpipe[i] <= tpipe[i-1];
    end
    assign tree_sum = tpipe[TL-1];

    function automatic logic [VW-1:0] mkvec(input int i, input int c, input int pat);
        logic [VW-1:0] v;
        for (int k = 0; k < NA; k++) begin
            if (pat == 1)      v[k*AL +: AL] = 16'd1;
            else if (pat == 2) v[k*AL +: AL] = 16'hFFFF;
            else               v[k*AL +: AL] = 16'(i*1000 + c*37 + k*3 + 5);
        end
        return v;
    endfunction

    typedef struct {
        bit         rst_n;
        bit         drn;
        logic [3:0] vld;
        int         pat;
        logic [3:0] ready;
        bit         done;
    } row_t;

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [31:0] sum;
    } exp_t;

    row_t tbl [ROWS];
    exp_t sb [$];
    int   nvec  = 0;
    int   nfail = 0;
    int   cyc   = 0;

    task automatic row(input int c, input bit rn, input bit d, input logic [3:0] v,
                       input int p, input logic [3:0] r, input bit dn);
        tbl[c] = '{rst_n: rn, drn: d, vld: v, pat: p, ready: r, done: dn};
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        logic [VW-1:0] exp_tree;
        rst         = 1'b0;
        drain       = 1'b0;
        req_valid   = '0;
        req_addends = '0;
`ifdef ADDER_TREE_ARB_STATS_EN
        stat_clr    = 1'b0;
`endif
        for (int c = 0; c < ROWS; c++) row(c, 1, 0, 4'h0, 0, 4'h0, 0);
        row(0, 0, 0, 4'h0, 0, 4'h0, 0);
        row(1, 0, 0, 4'hF, 0, 4'h0, 0);
        row(3, 1, 0, 4'b0010, 1, 4'b0010, 0);
        row(10, 1, 0, 4'b1000, 2, 4'b1000, 0);
        for (int k = 0; k < 8; k++) row(12 + k, 1, 0, 4'hF, 0, 4'(4'b0001 << (k % 4)), 0);
        row(20, 1, 0, 4'hF, 0, 4'b0001, 0);
        row(21, 1, 0, 4'hF, 0, 4'b0010, 0);
        row(22, 1, 1, 4'hF, 0, 4'b0100, 0);
        for (int c = 23; c <= 28; c++) row(c, 1, 1, 4'hF, 0, 4'h0, 0);
        row(29, 1, 1, 4'hF, 0, 4'h0, 1);
        row(30, 1, 1, 4'hF, 0, 4'h0, 1);
        row(31, 1, 0, 4'hF, 0, 4'h0, 1);
        row(32, 1, 0, 4'hF, 0, 4'b1000, 0);
        row(33, 1, 0, 4'hF, 0, 4'b0001, 0);
        row(35, 0, 0, 4'hF, 0, 4'h0, 0);
        row(41, 1, 0, 4'hF, 0, 4'b0001, 0);
        row(42, 1, 0, 4'b0110, 0, 4'b0010, 0);
        row(43, 1, 0, 4'b0110, 0, 4'b0100, 0);
        row(51, 1, 1, 4'h0, 0, 4'h0, 0);
        row(52, 1, 0, 4'h0, 0, 4'h0, 0);
        row(53, 1, 0, 4'b0001, 0, 4'h0, 1);
        row(54, 1, 0, 4'b0001, 0, 4'b0001, 0);

        for (int c = 0; c < ROWS; c++) begin
            @(negedge clk);
            cyc       = c;
            rst       = tbl[c].rst_n;
            drain     = tbl[c].drn;
            req_valid = tbl[c].vld;
            for (int i = 0; i < NR; i++) req_addends[i*VW +: VW] = mkvec(i, c, tbl[c].pat);
            #1;
            if (!tbl[c].rst_n) sb.delete();
            chk("req_ready", 256'(req_ready), 256'(tbl[c].ready));
            chk("drain_done", 256'(drain_done), 256'(tbl[c].done));
            chk("busy", 256'(busy), 256'(sb.size() != 0));
            exp_tree = '0;
            for (int i = 0; i < NR; i++) if (tbl[c].ready[i]) exp_tree = mkvec(i, c, tbl[c].pat);
            chk("tree_addends", 256'(tree_addends), 256'(exp_tree));
            if (sb.size() != 0 && sb[0].due == c) begin
                chk("res_valid", 256'(res_valid), 256'(1));
                chk("res_id", 256'(res_id), 256'(sb[0].id));
                chk("res_sum", 256'(res_sum), 256'(sb[0].sum));
                void'(sb.pop_front());
            end else begin
                chk("res_valid_idle", 256'(res_valid), 256'(0));
            end
            for (int i = 0; i < NR; i++) begin
                if (tbl[c].ready[i]) sb.push_back('{due: c + TL, id: 2'(i), sum: vsum(mkvec(i, c, tbl[c].pat))});
            end
        end
        chk("sb_empty", 256'(sb.size()), 256'(0));

`ifdef ADDER_TREE_ARB_STATS_EN
        @(negedge clk);
        rst = 1'b0; req_valid = '0; drain = 1'b0;
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        chk("stat_req2", 256'(stat_grants[47:32]), 256'(3));
        chk("stat_req0", 256'(stat_grants[15:0]), 256'(0));
        @(negedge clk);
        req_valid = 4'b0100; stat_clr = 1'b1;
        @(negedge clk);
        req_valid = '0; stat_clr = 1'b0;
        #1;
        chk("stat_clr", 256'(stat_grants[47:32]), 256'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_tree_arbiter.md
Name: adder_tree_arbiter

Overview:
- Shares one pipelined adder_tree instance between NUM_REQ requesters. Each requester presents a full addend vector.
- Per cycle, grants at most one requester in round-robin order and drives the winning vector onto the tree input.
- Tags each issue with the requester ID so it can be matched to its result TREE_LAT cycles later.
- Provides a drain sequence that stops issue and reports when the tree holds no in-flight work.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ADD_LENGTH, 16, addend width in bits.
- SUM_LENGTH, 32, tree sum width in bits.
- NUM_ADDEND, 15, addends per vector.
- TREE_LAT, 5, cycles from a tree-input sample to a valid tree sum (clog2(NUM_ADDEND)+1).
- ID_W, clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: one clock, synchronous, active-low (asserted when 0).
- req_valid  in  NUM_REQ  per-requester vector valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- req_addends  in  NUM_REQ*NUM_ADDEND*ADD_LENGTH  packed vectors; requester i occupies slice i.
- tree_addends  out  NUM_ADDEND*ADD_LENGTH  to adder_tree.addends.
- tree_sum  in  SUM_LENGTH  from adder_tree.sum.
- res_valid  out  1  result valid, single-cycle pulse, no backpressure.
- res_id  out  ID_W  requester owning the result.
- res_sum  out  SUM_LENGTH  result value (tree_sum passthrough).
- drain  in  1  level request to stop issuing.
- drain_done  out  1  high while in DONE.
- busy  out  1  high while any tag is in flight.

Behaviour:
- Handshake: transfer when req_valid[i] && req_ready[i] in the same cycle.
  - req_ready is combinational from req_valid, the round-robin pointer and the state.
  - req_ready is high only in RUN.
  - A requester must hold req_valid and its vector stable until the transfer.
- Arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ; the first valid requester wins.
  - last_grant updates only on a transfer.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 has first priority.
- tree_addends = winner's vector on a transfer cycle, otherwise all zeros.
- Tag pipeline: TREE_LAT stages of {v, id}, shifting every cycle; stage 0 loads {transfer, winner}.
  - res_valid = v at the last stage.
  - res_id = id at the last stage.
  - res_sum = tree_sum.
  - Transfer in cycle t gives res_valid in cycle t+TREE_LAT exactly.
  - Back-to-back transfers give back-to-back results in issue order.
- Tree reset is not relied on: tree_sum is ignored whenever res_valid=0.
- busy = OR of all tag v bits.
- FSM states: RUN, DRAIN, DONE.
  - RUN: issue allowed. drain=1 -> DRAIN. An issue in the same cycle drain rises still completes.
  - DRAIN: no grants. busy=0 -> DONE. This can be the next cycle if the pipeline is already empty.
  - DONE: drain_done=1, no grants. drain=0 -> RUN.
  - If drain falls while in DRAIN, still go to DONE first; from DONE, drain=0 -> RUN on the following edge.
- Reset (rst=0 at an edge), including mid-operation:
  - state=RUN, last_grant=NUM_REQ-1, all tag v=0.
  - So res_valid=0, busy=0, drain_done=0, req_ready=0 during the reset cycle.
  - In-flight results are discarded, never reported.
- Widths: the tree zero-extends addends; this block does not check overflow.

Optional Feature:
- Macro: ADDER_TREE_ARB_STATS_EN.
- When defined:
  - Added input stat_clr (1).
  - Added output stat_grants (NUM_REQ*16): per-requester 16-bit grant counters.
  - Each counter increments on its requester's transfer and saturates at 16'hFFFF.
  - Counters are cleared by reset or by stat_clr; stat_clr wins over a same-cycle increment.
- When undefined: no counters, no extra ports; all other behaviour is identical.

Decomposition:
- Package adder_tree_pkg holds:
  - state encoding typedef (RUN=0, DRAIN=1, DONE=2);
  - STAT_W=16 constant;
  - function computing default TREE_LAT from NUM_ADDEND.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with pointer update on accept). Reusable elsewhere.
- The tag pipeline and FSM stay in the top level.

Test Plan:
- Single request: req_valid=4'b0010, vector of 15 ones in cycle 3 -> req_ready=4'b0010 in cycle 3; res_valid=1, res_id=1, res_sum=15 in cycle 8 only.
- All four valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; results in the same id order, one per cycle, starting 5 cycles after the first grant.
- Vector of all 16'hFFFF -> res_sum=32'h000E_FFF1 with no truncation.
- drain=1 with 3 results in flight -> req_ready=0 from the next cycle; drain_done rises the cycle after busy falls; all 3 results delivered; drain=0 -> grants resume.
- rst=0 for one cycle with 2 results in flight -> res_valid stays 0 for the next TREE_LAT cycles; after release, requester 0 wins first.
- With ADDER_TREE_ARB_STATS_EN: 3 grants to requester 2 -> stat_grants[47:32]=3; stat_clr coincident with a grant -> 0.
